// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back controller for the single-cycle RISC-V core.
// Selects ALU / load / PC+4 as the write-back source, waits for load data,
// extends it, and drives a registered one-hot write enable, strobe and data.
// Optional build macro: WB_LOAD_TIMEOUT_EN adds a LOAD_WAIT timeout that
// abandons the load and pulses load_err after TIMEOUT_CYCLES cycles.
module wb_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wb_sel,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] out,
    output logic        reg_write,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        load_err
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W  = 3;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    // A zero timeout would make every load fail immediately
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [F3_W-1:0]   funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [XLEN-1:0]   out_q, out_d;
    logic              reg_write_q, reg_write_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              busy_q, busy_d;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 32'($clog2(TIMEOUT_CYCLES + 1)) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              load_err_q, load_err_d;
`endif

    // Byte lane picked by the address offset, halfword by offset bit 1
    function automatic logic [XLEN-1:0] extend_load(input logic [F3_W-1:0] f3,
                                                    input logic [1:0]      off,
                                                    input logic [XLEN-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // Next-state and next-output logic; outputs idle at zero unless a write issues
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        out_d       = '0;
        reg_write_d = 1'b0;
        wb_data_d   = '0;
        busy_d      = 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt_d       = cnt_q;
        load_err_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (in_wb_sel)
                        SEL_ALU, SEL_PC4: begin
                            if (in_rd != '0) begin
                                reg_write_d = 1'b1;
                                out_d       = XLEN'(1) << in_rd;
                                wb_data_d   = (in_wb_sel == SEL_ALU) ? in_alu_result : in_pc_plus4;
                            end
                        end
                        SEL_LOAD: begin
                            rd_d     = in_rd;
                            funct3_d = in_funct3;
                            off_d    = in_alu_result[1:0];
                            state_d  = LOAD_WAIT;
                            busy_d   = 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
                            cnt_d    = '0;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_WAIT: begin
                busy_d = 1'b1;
                if (dmem_rvalid) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (rd_q != '0) begin
                        reg_write_d = 1'b1;
                        out_d       = XLEN'(1) << rd_q;
                        wb_data_d   = extend_load(funct3_q, off_q, dmem_rdata);
                    end
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    load_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending-load and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            out_q       <= '0;
            reg_write_q <= 1'b0;
            wb_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            out_q       <= out_d;
            reg_write_q <= reg_write_d;
            wb_data_q   <= wb_data_d;
            busy_q      <= busy_d;
        end
    end

`ifdef WB_LOAD_TIMEOUT_EN
    // Timeout counter and error pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;
`else
    assign load_err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out       = out_q;
    assign reg_write = reg_write_q;
    assign wb_data   = wb_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed self-checking bench for wb_ctrl.
module tb_wb_ctrl;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [31:0] out;
    logic        reg_write;
    logic [31:0] wb_data;
    logic        busy;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    wb_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_alu_result (in_alu_result),
        .in_pc_plus4   (in_pc_plus4),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .out           (out),
        .reg_write     (reg_write),
        .wb_data       (wb_data),
        .busy          (busy),
        .load_err      (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".reg_write"}, 32'(reg_write), 32'd0);
        check({tag, ".out"},       out,            32'd0);
        check({tag, ".wb_data"},   wb_data,        32'd0);
    endtask

    // Non-load issue; checks the registered write one cycle later
    task automatic issue(input string tag, input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic exp_we, input logic [31:0] exp_out,
                         input logic [31:0] exp_data);
        in_valid = 1'b1; in_wb_sel = sel; in_rd = rd;
        in_alu_result = alu; in_pc_plus4 = pc4;
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check({tag, ".reg_write"}, 32'(reg_write), 32'(exp_we));
        check({tag, ".out"},       out,            exp_out);
        check({tag, ".wb_data"},   wb_data,        exp_data);
    endtask

    // Load with the response gap cycles after acceptance
    task automatic load_op(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata, input int gap,
                           input logic exp_we, input logic [31:0] exp_out,
                           input logic [31:0] exp_data);
        in_valid = 1'b1; in_wb_sel = 2'b01; in_rd = rd; in_funct3 = f3;
        in_alu_result = addr;
        tick();
        in_valid = 1'b0;
        check({tag, ".busy"},      32'(busy),      32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".wait_we"},   32'(reg_write), 32'd0);
        for (int i = 0; i < gap; i++) begin
            tick();
            check({tag, ".wait_busy"}, 32'(busy), 32'd1);
        end
        dmem_rvalid = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        check({tag, ".reg_write"}, 32'(reg_write), 32'(exp_we));
        check({tag, ".out"},       out,            exp_out);
        check({tag, ".wb_data"},   wb_data,        exp_data);
        check({tag, ".done_busy"}, 32'(busy),      32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".load_err"},  32'(load_err),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_rd = '0; in_wb_sel = '0; in_funct3 = '0;
        in_alu_result = '0; in_pc_plus4 = '0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick(); tick();
        check_idle_outputs("rst");
        check("rst.busy",     32'(busy),     32'd0);
        check("rst.load_err", 32'(load_err), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        tick();

        // Single ALU write
        issue("alu5", 2'b00, 5'd5, 32'h1234_5678, 32'h0, 1'b1, 32'h0000_0020, 32'h1234_5678);
        tick();
        check_idle_outputs("alu5_after");

        // Back-to-back ALU writes
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_wb_sel = 2'b00; in_rd = 5'(i); in_alu_result = 32'(i) * 32'h11;
            check("b2b.in_ready", 32'(in_ready), 32'd1);
            tick();
            check("b2b.reg_write", 32'(reg_write), 32'd1);
            check("b2b.out",       out,            32'(1) << i);
            check("b2b.wb_data",   wb_data,        32'(i) * 32'h11);
        end
        in_valid = 1'b0;
        tick();
        check_idle_outputs("b2b_after");

        // Loads: LB lane 2, LHU upper half, LW with offset, LB lane 3 positive, LH lower half
        load_op("lb",  5'd7,  3'b000, 32'h1000_0002, 32'h0080_0000, 2, 1'b1, 32'h0000_0080, 32'hFFFF_FF80);
        load_op("lhu", 5'd12, 3'b101, 32'h2000_0002, 32'hBEEF_0000, 1, 1'b1, 32'h0000_1000, 32'h0000_BEEF);
        load_op("lw",  5'd31, 3'b010, 32'h3000_0003, 32'hDEAD_BEEF, 0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF);
        load_op("lb3", 5'd4,  3'b000, 32'h0000_0003, 32'h7F00_00FF, 0, 1'b1, 32'h0000_0010, 32'h0000_007F);
        load_op("lh",  5'd6,  3'b001, 32'h0000_0000, 32'h1234_8001, 1, 1'b1, 32'h0000_0040, 32'hFFFF_8001);
        load_op("lbu", 5'd8,  3'b100, 32'h0000_0001, 32'h0000_F000, 0, 1'b1, 32'h0000_0100, 32'h0000_00F0);
        load_op("f3_7", 5'd9, 3'b111, 32'h0000_0002, 32'hCAFE_F00D, 0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D);

        // Instruction accepted in the same cycle the load write appears
        load_op("lw_cc", 5'd2, 3'b010, 32'h0, 32'h5555_AAAA, 0, 1'b1, 32'h0000_0004, 32'h5555_AAAA);
        issue("after_load", 2'b00, 5'd9, 32'h0000_00A5, 32'h0, 1'b1, 32'h0000_0200, 32'h0000_00A5);

        // rd=0 never writes, for every source
        issue("pc4_rd0", 2'b10, 5'd0, 32'h0, 32'h0000_0104, 1'b0, 32'h0, 32'h0);
        issue("alu_rd0", 2'b00, 5'd0, 32'h9, 32'h0, 1'b0, 32'h0, 32'h0);
        load_op("ld_rd0", 5'd0, 3'b010, 32'h0, 32'hFFFF_FFFF, 1, 1'b0, 32'h0, 32'h0);

        // PC+4 link and no-write select
        issue("pc4", 2'b10, 5'd1, 32'hFFFF_0000, 32'h0000_0104, 1'b1, 32'h0000_0002, 32'h0000_0104);
        issue("nowb", 2'b11, 5'd3, 32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0, 32'h0);

        // Stray response in IDLE
        dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_FFFF; in_rd = 5'd3;
        tick();
        dmem_rvalid = 1'b0;
        check_idle_outputs("stray");
        check("stray.busy",     32'(busy),     32'd0);
        check("stray.in_ready", 32'(in_ready), 32'd1);

        // Reset during LOAD_WAIT, later response ignored
        in_valid = 1'b1; in_wb_sel = 2'b01; in_rd = 5'd3; in_funct3 = 3'b010; in_alu_result = 32'h0;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrst.busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_idle_outputs("midrst");
        check("midrst.busy",     32'(busy),     32'd0);
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        tick();
        reset = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        check_idle_outputs("midrst_rv");
        check("midrst_rv.busy",     32'(busy),     32'd0);
        check("midrst_rv.in_ready", 32'(in_ready), 32'd1);

`ifdef WB_LOAD_TIMEOUT_EN
        // No response: error pulse on the 4th waiting cycle
        in_valid = 1'b1; in_wb_sel = 2'b01; in_rd = 5'd10; in_funct3 = 3'b010;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("to.wait_err",  32'(load_err), 32'd0);
            check("to.wait_busy", 32'(busy),     32'd1);
            tick();
        end
        check("to.wait_err3", 32'(load_err), 32'd0);
        tick();
        check("to.load_err",  32'(load_err),  32'd1);
        check("to.reg_write", 32'(reg_write), 32'd0);
        check("to.out",       out,            32'd0);
        check("to.busy",      32'(busy),      32'd0);
        check("to.in_ready",  32'(in_ready),  32'd1);
        tick();
        check("to.err_pulse", 32'(load_err), 32'd0);

        // Response on the timeout cycle wins
        load_op("to_race", 5'd11, 3'b010, 32'h0, 32'h0BAD_F00D, 3, 1'b1, 32'h0000_0800, 32'h0BAD_F00D);
`else
        // Without the timeout a load waits indefinitely
        load_op("longwait", 5'd11, 3'b010, 32'h0, 32'h0BAD_F00D, 20, 1'b1, 32'h0000_0800, 32'h0BAD_F00D);
`endif
        tick();
        check_idle_outputs("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
Name: wb_ctrl

Overview:
- Write-back controller for the single-cycle RISC-V core; the producer side of the register-file write port.
- Takes retiring instructions and selects the write-back source: ALU result, load data or PC+4.
- Waits for data-memory load responses and sign/zero-extends load data.
- Drives the register file's one-hot write-enable vector, reg_write strobe and write data, registered.

Parameters:
TIMEOUT_CYCLES, 255, max cycles to wait for dmem_rvalid (used only when WB_LOAD_TIMEOUT_EN is defined)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  retiring instruction presented
in_ready  out  1  controller accepts instruction this cycle
in_rd  in  5  destination register index
in_wb_sel  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 no write
in_funct3  in  3  load width/sign (LOAD only)
in_alu_result  in  32  ALU result; load address for LOAD
in_pc_plus4  in  32  link value
dmem_rvalid  in  1  load data valid, single-cycle pulse
dmem_rdata  in  32  aligned 32-bit word from data memory
out  out  32  one-hot register write enable, bit i = register i
reg_write  out  1  write strobe
wb_data  out  32  write data
busy  out  1  load outstanding
load_err  out  1  load timeout pulse (macro only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, async): state IDLE; out=0, reg_write=0, wb_data=0, busy=0, load_err=0; pending rd/funct3/offset cleared.
- States: IDLE, LOAD_WAIT.
- IDLE:
  - in_ready=1. A transfer occurs when in_valid && in_ready.
  - ALU / PC+4 transfer: next cycle reg_write=1, out=1<<in_rd, wb_data=in_alu_result / in_pc_plus4. One-cycle latency, back-to-back accepted every cycle.
  - Write when in_wb_sel=11: next cycle reg_write=0, out=0.
  - LOAD transfer: capture rd, funct3, addr[1:0]; go to LOAD_WAIT; busy=1 from next cycle.
  - Outputs return to zero in any cycle with no issued write; reg_write is a single-cycle strobe per write.
- LOAD_WAIT:
  - in_ready=0.
  - On dmem_rvalid: next cycle reg_write=1, out=1<<rd, wb_data=extended data; state→IDLE, busy=0 in that same cycle.
  - in_ready returns to 1 in that cycle, so a new instruction can be accepted concurrently with the load write.
- rd=0: never write. reg_write=0 and out=0 for every source, including loads; the load still completes the handshake.
- Load extension, byte lane by addr[1:0], halfword by addr[1]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other codes: treated as LW.
  - Misalignment is not checked; LW ignores offset.
- dmem_rvalid in IDLE is ignored: no write, no state change.
- Reset mid-load: abort to IDLE; a later dmem_rvalid is ignored.
- out has at most one bit set; out!=0 implies reg_write=1.

Optional Feature:
WB_LOAD_TIMEOUT_EN
- Defined:
  - 8+ bit counter runs in LOAD_WAIT, cleared on entry.
  - If TIMEOUT_CYCLES cycles elapse without dmem_rvalid: state→IDLE, no register write, load_err=1 for one cycle, busy=0.
  - A dmem_rvalid arriving on the timeout cycle wins: normal write, no error.
- Undefined: no counter; LOAD_WAIT waits indefinitely; load_err tied 0.

Test Plan:
- Reset released; in_valid=1, rd=5, sel=ALU, alu=0x1234_5678 → next cycle reg_write=1, out=0x0000_0020, wb_data=0x1234_5678.
- Three back-to-back ALU ops to rd=1,2,3 → three consecutive write cycles, out=0x2,0x4,0x8; in_ready stays 1.
- LOAD rd=7, funct3=000, addr=…02, dmem_rdata=0x0080_0000 returned after 3 cycles → busy=1, in_ready=0 while waiting; then wb_data=0xFFFF_FF80, out=0x80.
  - Repeat with funct3=101, addr=…02, rdata=0xBEEF_0000 → wb_data=0x0000_BEEF.
- rd=0 with sel=PC+4, pc_plus4=0x104 → reg_write=0, out=0; stray dmem_rvalid in IDLE → no write.
- Assert reset during LOAD_WAIT, then pulse dmem_rvalid → all outputs 0, no write, in_ready=1.
- With WB_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4: LOAD with no response → load_err pulses once after 4 cycles, no write, return to IDLE.
  - Response on the 4th cycle → normal write, load_err=0.
